// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register bank definitions: response codes, FSM states,
// register count and the pattern returned for unmapped reads.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS = 4;

  localparam logic [31:0] SLVERR_RDATA = 32'hDEC0DE00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational register-bank address decode: index from addr[15:14],
// mapped only when the low 14 bits are zero.
module axil_addr_decode #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            idx,
  output logic                  mapped
);

  // Bits above the 64 KiB window do not take part in decoding.
  logic unused_upper;
  assign unused_upper = ^addr[ADDR_WIDTH-1:16];

  assign idx    = addr[15:14];
  assign mapped = (addr[13:0] == 14'd0);

endmodule

// File: rtl/axil_reg_bank_slave.sv
// AXI4-Lite slave exposing four 32-bit registers with independent read and write FSMs.
// Optional macro AXIL_REG_BANK_SLVERR_EN makes unmapped accesses answer SLVERR.
module axil_reg_bank_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0]            UNMAPPED_RESP  = RESP_SLVERR;
  localparam logic [DATA_WIDTH-1:0] UNMAPPED_RDATA = SLVERR_RDATA;
`else
  localparam logic [1:0]            UNMAPPED_RESP  = RESP_OKAY;
  localparam logic [DATA_WIDTH-1:0] UNMAPPED_RDATA = '0;
`endif

  w_state_e                w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  r_state_e                r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    awready_int, wready_int, aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic [DATA_WIDTH/8-1:0] commit_strb;
  logic [1:0]              wr_idx, rd_idx;
  logic                    wr_mapped, rd_mapped;

  assign awready_int = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
  assign wready_int  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
  assign aw_hs       = s_axi_awvalid && awready_int;
  assign w_hs        = s_axi_wvalid && wready_int;

  // The commit uses whichever half was latched earlier plus the half arriving now.
  assign commit_addr = (w_state_q == W_HAVE_AW) ? awaddr_q : s_axi_awaddr;
  assign commit_data = (w_state_q == W_HAVE_W) ? wdata_q : s_axi_wdata;
  assign commit_strb = (w_state_q == W_HAVE_W) ? wstrb_q : s_axi_wstrb;

  axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_decode (
    .addr   (commit_addr),
    .idx    (wr_idx),
    .mapped (wr_mapped)
  );

  axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_decode (
    .addr   (s_axi_araddr),
    .idx    (rd_idx),
    .mapped (rd_mapped)
  );

  always_comb begin
    w_state_d  = w_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    commit     = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d  = s_axi_awaddr;
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) commit = 1'b1;
      W_HAVE_W:  if (aw_hs) commit = 1'b1;
      W_RESP:    if (s_axi_bready) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase

    if (commit) begin
      w_state_d = W_RESP;
      if (wr_mapped) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (commit_strb[b]) regs_d[wr_idx][8*b +: 8] = commit_data[8*b +: 8];
        end
        wr_pulse_d[wr_idx] = 1'b1;
        bresp_d            = RESP_OKAY;
      end else begin
        bresp_d = UNMAPPED_RESP;
      end
    end
  end

  // Reads sample regs_q before the edge, so a same-edge write is not visible yet.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rdata_d   = rd_mapped ? regs_q[rd_idx] : UNMAPPED_RDATA;
          rresp_d   = rd_mapped ? RESP_OKAY : UNMAPPED_RESP;
          r_state_d = R_DATA;
        end
      end
      R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      r_state_q  <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      r_state_q  <= r_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Outputs are forced quiet for the whole reset window, including its first cycle.
  assign s_axi_awready = !reset && awready_int;
  assign s_axi_wready  = !reset && wready_int;
  assign s_axi_bvalid  = !reset && (w_state_q == W_RESP);
  assign s_axi_bresp   = reset ? RESP_OKAY : bresp_q;
  assign s_axi_arready = !reset && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = !reset && (r_state_q == R_DATA);
  assign s_axi_rdata   = reset ? '0 : rdata_q;
  assign s_axi_rresp   = reset ? RESP_OKAY : rresp_q;
  assign wr_pulse_o    = reset ? '0 : wr_pulse_q;

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = reset ? '0 : regs_q[i];
    end
  end

endmodule
